// File: rtl/instru_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words and writes
// them to instruction memory, holding the core in reset until the image is in.
// Optional trailing XOR checksum word is enabled by defining LOADER_CHECKSUM_EN.
module instru_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              im_we,
  output logic [31:0]       im_addr,
  output logic [31:0]       im_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_HDR,
    S_LOAD,
`ifdef LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [31:0] HDR_MAX = 32'(1) << ADDR_W;

  state_t            state_q, state_d;
  logic [1:0]        lane_q, lane_d;
  logic [23:0]       buf_q, buf_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [ADDR_W:0]   wl_q, wl_d;
  logic              rx_ready_q, rx_ready_d;
  logic              im_we_q, im_we_d;
  logic [31:0]       im_addr_q, im_addr_d;
  logic [31:0]       im_wdata_q, im_wdata_d;
  logic              core_rst_q, core_rst_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       chk_q, chk_d;
`endif

  logic        fire;
  logic        word_end;
  logic [31:0] word;

  assign fire     = rx_valid && rx_ready_q;
  assign word_end = fire && (lane_q == 2'd3);
  // Earlier bytes sit in buf_q, newest on top, so the arriving byte is the MSB.
  assign word     = {rx_data, buf_q};

  always_comb begin
    // NOTE: every next-state value gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    lane_d     = lane_q;
    buf_d      = buf_q;
    n_d        = n_q;
    wl_d       = wl_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
`ifdef LOADER_CHECKSUM_EN
    chk_d      = chk_q;
`endif

    if (fire) begin
      lane_d = lane_q + 2'd1;
      buf_d  = {rx_data, buf_q[23:8]};
    end

    case (state_q)
      S_HDR: begin
`ifdef LOADER_CHECKSUM_EN
        chk_d = '0;
`endif
        if (word_end) begin
          if (word > HDR_MAX) begin
            state_d = S_ERR;
          end else if (word == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
          end else begin
            n_d     = word[ADDR_W:0];
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (word_end) begin
          im_we_d    = 1'b1;
          im_addr_d  = BASE_ADDR + (32'(wl_q) << 2);
          im_wdata_d = word;
          wl_d       = wl_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
          chk_d      = chk_q ^ word;
          if (wl_d == n_q) state_d = S_CHK;
`else
          if (wl_d == n_q) state_d = S_DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (word_end) state_d = (word == chk_q) ? S_DONE : S_ERR;
      end
`endif
      default: ;
    endcase

    // Status outputs are registered copies of the state being entered, so they
    // change on the same edge as the transition.
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERR);
    core_rst_d = (state_d != S_DONE);
    rx_ready_d = (state_d != S_DONE) && (state_d != S_ERR);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= S_HDR;
      lane_q     <= 2'd0;
      buf_q      <= '0;
      n_q        <= '0;
      wl_q       <= '0;
      rx_ready_q <= 1'b0;
      im_we_q    <= 1'b0;
      im_addr_q  <= BASE_ADDR;
      im_wdata_q <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      buf_q      <= buf_d;
      n_q        <= n_d;
      wl_q       <= wl_d;
      rx_ready_q <= rx_ready_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef LOADER_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  assign rx_ready     = rx_ready_q;
  assign im_we        = im_we_q;
  assign im_addr      = im_addr_q;
  assign im_wdata     = im_wdata_q;
  assign core_rst     = core_rst_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_instru_loader.sv
// Self-checking bench for instru_loader: table of whole-image loads plus directed
// sequences for header timing, mid-load reset and (when enabled) checksum checks.
module tb_instru_loader;
  localparam int          ADDR_W = 8;
  localparam logic [31:0] BASE   = 32'h0000_0000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      rx_data = 8'h00;
  logic            rx_valid = 1'b0;
  logic            rx_ready;
  logic            im_we;
  logic [31:0]     im_addr;
  logic [31:0]     im_wdata;
  logic            core_rst;
  logic            done;
  logic            error;
  logic [ADDR_W:0] words_loaded;

  always #5 clk = ~clk;

  instru_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .core_rst(core_rst), .done(done), .error(error), .words_loaded(words_loaded)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Write monitor: records every im_we pulse, sampled on the falling edge.
  int          wr_n = 0;
  logic [31:0] wr_addr [0:299];
  logic [31:0] wr_data [0:299];
  logic        last_we_done = 1'b0;
  always @(negedge clk) begin
    if (im_we) begin
      if (wr_n < 300) begin
        wr_addr[wr_n] = im_addr;
        wr_data[wr_n] = im_wdata;
      end
      wr_n++;
      last_we_done = done;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] hdr;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          bubble;
    bit          exp_done;
    bit          exp_err;
    int          exp_wl;
  } vec_t;

  vec_t vt [6];

  function automatic logic [31:0] pay(input vec_t v, input int i);
    if (i == 0) return v.w0;
    if (i == 1) return v.w1;
    return 32'hA500_0000 | 32'(i);
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit bubble);
    int t;
    if (bubble) begin
      rx_valid = 1'b0;
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (!rx_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit bubble);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], bubble);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_im_we"},    32'(im_we), 32'd0);
    check({tag, "_im_addr"},  im_addr, BASE);
    check({tag, "_im_wdata"}, im_wdata, 32'd0);
    check({tag, "_core_rst"}, 32'(core_rst), 32'd1);
    check({tag, "_done"},     32'(done), 32'd0);
    check({tag, "_error"},    32'(error), 32'd0);
    check({tag, "_wl"},       32'(words_loaded), 32'd0);
  endtask

  initial begin
    int          base;
    logic [31:0] xs;
    logic [31:0] w;
    bit          ck_en;
`ifdef LOADER_CHECKSUM_EN
    ck_en = 1'b1;
`else
    ck_en = 1'b0;
`endif

    //          hdr     nw   w0            w1            bub   done  err   wl
    vt[0] = '{32'd2,   2,   32'h20080005, 32'h2009000A, 1'b0, 1'b1, 1'b0, 2};
    vt[1] = '{32'd2,   2,   32'h20080005, 32'h2009000A, 1'b1, 1'b1, 1'b0, 2};
    vt[2] = '{32'd0,   0,   32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 0};
    vt[3] = '{32'd257, 0,   32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 0};
    vt[4] = '{32'd1,   1,   32'h12345678, 32'h0,        1'b1, 1'b1, 1'b0, 1};
    vt[5] = '{32'd256, 256, 32'hA5000000, 32'hA5000001, 1'b0, 1'b1, 1'b0, 256};

    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    check("rx_ready_after_reset", 32'(rx_ready), 32'd1);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      base = wr_n;
      xs   = '0;
      send_word(vt[v].hdr, vt[v].bubble);
      for (int i = 0; i < vt[v].nw; i++) begin
        w  = pay(vt[v], i);
        xs = xs ^ w;
        send_word(w, vt[v].bubble);
      end
      if (ck_en && !vt[v].exp_err) send_word(xs, vt[v].bubble);
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_wr_count", v), 32'(wr_n - base), 32'(vt[v].exp_wl));
      for (int i = 0; i < vt[v].exp_wl && base + i < 300; i++) begin
        check($sformatf("v%0d_addr%0d", v, i), wr_addr[base + i], BASE + 32'(4 * i));
        check($sformatf("v%0d_data%0d", v, i), wr_data[base + i], pay(vt[v], i));
      end
      if (vt[v].exp_wl > 0)
        check($sformatf("v%0d_done_at_last_we", v), 32'(last_we_done), 32'(!ck_en));
      check($sformatf("v%0d_done", v),     32'(done), 32'(vt[v].exp_done));
      check($sformatf("v%0d_error", v),    32'(error), 32'(vt[v].exp_err));
      check($sformatf("v%0d_core_rst", v), 32'(core_rst), 32'(!vt[v].exp_done));
      check($sformatf("v%0d_rx_ready", v), 32'(rx_ready), 32'd0);
      check($sformatf("v%0d_wl", v),       32'(words_loaded), 32'(vt[v].exp_wl));
    end

    // Empty image: completion timing right after the 4th header byte.
    do_reset();
    base = wr_n;
    send_word(32'd0, 1'b0);
    check("empty_done_now", 32'(done), 32'(!ck_en));
    check("empty_rx_ready_now", 32'(rx_ready), 32'(ck_en));
    if (ck_en) begin
      send_word(32'd0, 1'b0);
      check("empty_chk_done", 32'(done), 32'd1);
    end
    check("empty_no_we", 32'(wr_n - base), 32'd0);

    // Oversize header: error on the cycle after the 4th header byte.
    do_reset();
    send_word(32'd257, 1'b0);
    check("oversize_error_now", 32'(error), 32'd1);
    check("oversize_core_rst", 32'(core_rst), 32'd1);
    check("oversize_rx_ready", 32'(rx_ready), 32'd0);

    // Mid-load reset after 6 payload bytes of an N=3 image, then a fresh load.
    do_reset();
    send_word(32'd3, 1'b0);
    send_word(32'h0102_0304, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h06, 1'b0);
    check("midrst_wl_before", 32'(words_loaded), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0;
    @(negedge clk);
    base = wr_n;
    send_word(32'd1, 1'b0);
    send_word(32'hDEAD_BEEF, 1'b0);
    if (ck_en) send_word(32'hDEAD_BEEF, 1'b0);
    repeat (2) @(negedge clk);
    check("midrst_wr_count", 32'(wr_n - base), 32'd1);
    if (wr_n > base && base < 300) begin
      check("midrst_addr", wr_addr[base], BASE);
      check("midrst_data", wr_data[base], 32'hDEAD_BEEF);
    end
    check("midrst_done", 32'(done), 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // Checksum match and mismatch on a two-word image.
    do_reset();
    send_word(32'd2, 1'b0);
    send_word(32'h1111_1111, 1'b0);
    send_word(32'h2222_2222, 1'b0);
    check("ck_wait_done", 32'(done), 32'd0);
    send_word(32'h3333_3333, 1'b0);
    check("ck_good_done", 32'(done), 32'd1);
    check("ck_good_core_rst", 32'(core_rst), 32'd0);
    do_reset();
    send_word(32'd2, 1'b0);
    send_word(32'h1111_1111, 1'b0);
    send_word(32'h2222_2222, 1'b0);
    send_word(32'h3333_3334, 1'b0);
    check("ck_bad_error", 32'(error), 32'd1);
    check("ck_bad_core_rst", 32'(core_rst), 32'd1);
    check("ck_bad_done", 32'(done), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
